// File: rtl/sm3_compress.sv
// SM3 compression function: one 64-round block per start, fed from an external schedule RAM.
// Define SM3_CHAIN_EN to keep the chaining value V between blocks for multi-block messages.
module sm3_compress (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic         i_first_block,
    input  logic         i_extend_valid,
    output logic [7:0]   o_rd_addr0,
    output logic [7:0]   o_rd_addr1,
    input  logic [31:0]  i_rd_data0,
    input  logic [31:0]  i_rd_data1,
    output logic         o_busy,
    output logic [255:0] o_hash,
    output logic         o_hash_valid
);

    localparam logic [255:0] InitVector = {
        32'h7380166F, 32'h4914B2B9, 32'h172442D7, 32'hDA8A0600,
        32'hA96F30BC, 32'h163138AA, 32'hE38DEE4D, 32'hB0FB0E4E
    };
    localparam logic [31:0] TjLow  = 32'h79CC4519;
    localparam logic [31:0] TjHigh = 32'h7A879D8A;
    localparam logic [7:0]  WpBase = 8'd68;

    typedef enum logic [1:0] {StIdle, StLoad, StRound, StFinal} state_e;

    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] t;
        t = {x, x} << n;
        return t[63:32];
    endfunction

    function automatic logic [31:0] p0(input logic [31:0] x);
        return x ^ rotl(x, 5'd9) ^ rotl(x, 5'd17);
    endfunction

    state_e state_q, state_d;
    logic [5:0]   j_q, j_d;
    logic [7:0]   addr0_q, addr0_d, addr1_q, addr1_d;
    logic [255:0] hash_q, hash_d;
    logic         valid_q, valid_d;
    logic [31:0]  a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q;
    logic [31:0]  a_d, b_d, c_d, d_d, e_d, f_d, g_d, h_d;

    // Chaining value feeding LOAD and the final feed-forward XOR.
    logic [255:0] load_base;
    logic [255:0] v_cur;

`ifdef SM3_CHAIN_EN
    logic [255:0] v_q, v_d;
    logic         first_q, first_d;

    assign load_base = first_q ? InitVector : v_q;
    assign v_cur     = v_q;
`else
    logic unused_first_block;

    assign unused_first_block = i_first_block;
    assign load_base          = InitVector;
    assign v_cur              = InitVector;
`endif

    // Round datapath
    logic [31:0] tj, a_rot12, ss1, ss2, ff, gg, tt1, tt2;

    always_comb begin
        tj      = (j_q < 6'd16) ? TjLow : TjHigh;
        a_rot12 = rotl(a_q, 5'd12);
        ss1     = rotl(a_rot12 + e_q + rotl(tj, j_q[4:0]), 5'd7);
        ss2     = ss1 ^ a_rot12;
        if (j_q < 6'd16) begin
            ff = a_q ^ b_q ^ c_q;
            gg = e_q ^ f_q ^ g_q;
        end else begin
            ff = (a_q & b_q) | (a_q & c_q) | (b_q & c_q);
            gg = (e_q & f_q) | (~e_q & g_q);
        end
        tt1 = ff + d_q + ss2 + i_rd_data1;
        tt2 = gg + h_q + ss1 + i_rd_data0;
    end

    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        addr0_d = addr0_q;
        addr1_d = addr1_q;
        hash_d  = hash_q;
        valid_d = 1'b0;
        a_d = a_q; b_d = b_q; c_d = c_q; d_d = d_q;
        e_d = e_q; f_d = f_q; g_d = g_q; h_d = h_q;
`ifdef SM3_CHAIN_EN
        v_d     = v_q;
        first_d = first_q;
`endif
        case (state_q)
            StIdle: begin
                if (i_start && i_extend_valid) begin
                    state_d = StLoad;
`ifdef SM3_CHAIN_EN
                    first_d = i_first_block;
`endif
                end
            end
            StLoad: begin
                {a_d, b_d, c_d, d_d, e_d, f_d, g_d, h_d} = load_base;
`ifdef SM3_CHAIN_EN
                v_d = load_base;
`endif
                j_d     = 6'd0;
                addr0_d = 8'd0;
                addr1_d = WpBase;
                state_d = StRound;
            end
            StRound: begin
                a_d = tt1;
                b_d = a_q;
                c_d = rotl(b_q, 5'd9);
                d_d = c_q;
                e_d = p0(tt2);
                f_d = e_q;
                g_d = rotl(f_q, 5'd19);
                h_d = g_q;
                // Addresses stop at 63/131 on the last round so they never leave the RAM.
                if (j_q == 6'd63) begin
                    state_d = StFinal;
                end else begin
                    j_d     = j_q + 6'd1;
                    addr0_d = addr0_q + 8'd1;
                    addr1_d = addr1_q + 8'd1;
                end
            end
            StFinal: begin
                hash_d  = v_cur ^ {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q};
                valid_d = 1'b1;
`ifdef SM3_CHAIN_EN
                v_d     = hash_d;
`endif
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            j_q     <= 6'd0;
            addr0_q <= 8'd0;
            addr1_q <= 8'd0;
            hash_q  <= '0;
            valid_q <= 1'b0;
            a_q <= '0; b_q <= '0; c_q <= '0; d_q <= '0;
            e_q <= '0; f_q <= '0; g_q <= '0; h_q <= '0;
`ifdef SM3_CHAIN_EN
            v_q     <= InitVector;
            first_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            addr0_q <= addr0_d;
            addr1_q <= addr1_d;
            hash_q  <= hash_d;
            valid_q <= valid_d;
            a_q <= a_d; b_q <= b_d; c_q <= c_d; d_q <= d_d;
            e_q <= e_d; f_q <= f_d; g_q <= g_d; h_q <= h_d;
`ifdef SM3_CHAIN_EN
            v_q     <= v_d;
            first_q <= first_d;
`endif
        end
    end

    assign o_rd_addr0   = addr0_q;
    assign o_rd_addr1   = addr1_q;
    assign o_busy       = (state_q != StIdle);
    assign o_hash       = hash_q;
    assign o_hash_valid = valid_q;

endmodule

// File: tb/tb_sm3_compress.sv
// Self-checking bench for sm3_compress: SM3 reference model, model schedule RAM, random blocks.
module tb_sm3_compress;

    localparam logic [255:0] IV = {
        32'h7380166F, 32'h4914B2B9, 32'h172442D7, 32'hDA8A0600,
        32'hA96F30BC, 32'h163138AA, 32'hE38DEE4D, 32'hB0FB0E4E
    };
    localparam logic [255:0] ABC_DIGEST = {
        32'h66C7F0F4, 32'h62EEEDD9, 32'hD1F2D46B, 32'hDC10E4E2,
        32'h4167C487, 32'h5CF2F7A2, 32'h297DA02B, 32'h8F4BA8E0
    };
    localparam logic [255:0] ABCD_DIGEST = {
        32'hDEBE9FF9, 32'h2275B8A1, 32'h38604889, 32'hC18E5A4D,
        32'h6FDB70E5, 32'h387E5765, 32'h293DCBA3, 32'h9C0C5732
    };
    localparam logic [511:0] ABC_BLOCK   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] ABCD_BLOCK1 = {16{32'h61626364}};
    localparam logic [511:0] ABCD_BLOCK2 = {32'h80000000, 448'h0, 32'h00000200};

    logic         clk = 1'b0;
    logic         rst, start, first_block, extend_valid;
    logic [7:0]   rd_addr0, rd_addr1;
    logic [31:0]  rd_data0, rd_data1;
    logic         busy, hash_valid;
    logic [255:0] hash;

    logic [31:0]  ram [0:131];
    logic [255:0] mv;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        rd_data0 = (rd_addr0 < 8'd132) ? ram[rd_addr0] : 32'hDEADBEEF;
        rd_data1 = (rd_addr1 < 8'd132) ? ram[rd_addr1] : 32'hDEADBEEF;
    end

    sm3_compress dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_first_block  (first_block),
        .i_extend_valid (extend_valid),
        .o_rd_addr0     (rd_addr0),
        .o_rd_addr1     (rd_addr1),
        .i_rd_data0     (rd_data0),
        .i_rd_data1     (rd_data1),
        .o_busy         (busy),
        .o_hash         (hash),
        .o_hash_valid   (hash_valid)
    );

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        int k;
        k = n % 32;
        if (k == 0) return x;
        return (x << k) | (x >> (32 - k));
    endfunction

    function automatic logic [31:0] p0f(input logic [31:0] x);
        return x ^ rl(x, 9) ^ rl(x, 17);
    endfunction

    function automatic logic [31:0] p1f(input logic [31:0] x);
        return x ^ rl(x, 15) ^ rl(x, 23);
    endfunction

    // Message expansion straight from the SM3 definition, written into the model RAM.
    task automatic load_block(input logic [511:0] m);
        logic [31:0] w [0:67];
        for (int i = 0; i < 16; i++) w[i] = m[511 - 32*i -: 32];
        for (int i = 16; i < 68; i++)
            w[i] = p1f(w[i-16] ^ w[i-9] ^ rl(w[i-3], 15)) ^ rl(w[i-13], 7) ^ w[i-6];
        for (int i = 0; i < 68; i++) ram[i] = w[i];
        for (int i = 0; i < 64; i++) ram[68 + i] = w[i] ^ w[i+4];
    endtask

    function automatic logic [255:0] ref_cf(input logic [255:0] v);
        logic [31:0] a, b, c, d, e, f, g, h, t, ss1, ss2, ff, gg, tt1, tt2;
        {a, b, c, d, e, f, g, h} = v;
        for (int j = 0; j < 64; j++) begin
            t   = (j < 16) ? 32'h79CC4519 : 32'h7A879D8A;
            ss1 = rl(rl(a, 12) + e + rl(t, j), 7);
            ss2 = ss1 ^ rl(a, 12);
            ff  = (j < 16) ? (a ^ b ^ c) : ((a & b) | (a & c) | (b & c));
            gg  = (j < 16) ? (e ^ f ^ g) : ((e & f) | (~e & g));
            tt1 = ff + d + ss2 + ram[68 + j];
            tt2 = gg + h + ss1 + ram[j];
            d = c; c = rl(b, 9); b = a; a = tt1;
            h = g; g = rl(f, 19); f = e; e = p0f(tt2);
        end
        return v ^ {a, b, c, d, e, f, g, h};
    endfunction

    task automatic model_run(input logic first, output logic [255:0] exp);
        logic [255:0] base;
`ifdef SM3_CHAIN_EN
        base = first ? IV : mv;
`else
        base = IV;
`endif
        exp = ref_cf(base);
        mv  = exp;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; first_block = 1'b0; extend_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mv  = IV;
    endtask

    // Starts one block and watches 120 cycles; cnt counts negedges after the accepting edge.
    task automatic run_block(input logic first, input int mid_at, input int rst_at,
                             output logic [255:0] got, output int lat, output int pulses,
                             output int trace_err, output int busy_err);
        int cnt;
        @(negedge clk);
        start = 1'b1; first_block = first; extend_valid = 1'b1;
        @(negedge clk);
        start = 1'b0; first_block = 1'b0;
        lat = -1; pulses = 0; trace_err = 0; busy_err = 0; got = hash;
        cnt = 1;
        while (cnt <= 120) begin
            if (hash_valid) begin
                pulses++;
                if (lat < 0) begin
                    lat = cnt;
                    got = hash;
                end
            end
            if (rst_at == 0) begin
                if (cnt >= 2 && cnt <= 65) begin
                    if (rd_addr0 != 8'(cnt - 2) || rd_addr1 != 8'(cnt + 66)) trace_err++;
                end else if (cnt >= 66) begin
                    if (rd_addr0 != 8'd63 || rd_addr1 != 8'd131) trace_err++;
                end
                if (busy !== (cnt <= 66)) busy_err++;
            end
            if (cnt == mid_at) start = 1'b1;
            if (cnt == mid_at + 1) start = 1'b0;
            if (cnt == rst_at) rst = 1'b1;
            if (cnt == rst_at + 1) rst = 1'b0;
            @(negedge clk);
            cnt++;
        end
        if (lat < 0) got = hash;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (hash_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", hash_valid); end
        checks++; if (hash !== 256'h0) begin errors++; $display("FAIL reset_hash got %h exp 0", hash); end
        checks++; if (rd_addr0 !== 8'd0) begin errors++; $display("FAIL reset_addr0 got %0d exp 0", rd_addr0); end
        checks++; if (rd_addr1 !== 8'd0) begin errors++; $display("FAIL reset_addr1 got %0d exp 0", rd_addr1); end
    endtask

    task automatic test_abc();
        logic [255:0] got, exp;
        int lat, pulses, terr, berr;
        load_block(ABC_BLOCK);
        model_run(1'b1, exp);
        run_block(1'b1, 0, 0, got, lat, pulses, terr, berr);
        checks++; if (got !== ABC_DIGEST) begin errors++; $display("FAIL abc_digest got %h exp %h", got, ABC_DIGEST); end
        checks++; if (lat != 67) begin errors++; $display("FAIL abc_latency got %0d exp 67", lat); end
        checks++; if (pulses != 1) begin errors++; $display("FAIL abc_pulses got %0d exp 1", pulses); end
        checks++; if (terr != 0) begin errors++; $display("FAIL addr_trace got %0d bad cycles exp 0", terr); end
        checks++; if (berr != 0) begin errors++; $display("FAIL busy_window got %0d bad cycles exp 0", berr); end
    endtask

    task automatic test_start_guard();
        logic [255:0] got, exp;
        int lat, pulses, terr, berr, busy_seen;
        @(negedge clk);
        extend_valid = 1'b0; start = 1'b1; first_block = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_seen = 0;
        repeat (5) begin
            if (busy || hash_valid) busy_seen++;
            @(negedge clk);
        end
        checks++; if (busy_seen != 0) begin errors++; $display("FAIL blocked_start got %0d active cycles exp 0", busy_seen); end
        load_block(ABC_BLOCK);
        model_run(1'b1, exp);
        run_block(1'b1, 30, 0, got, lat, pulses, terr, berr);
        checks++; if (got !== exp) begin errors++; $display("FAIL midstart_digest got %h exp %h", got, exp); end
        checks++; if (pulses != 1) begin errors++; $display("FAIL midstart_pulses got %0d exp 1", pulses); end
        checks++; if (lat != 67) begin errors++; $display("FAIL midstart_latency got %0d exp 67", lat); end
    endtask

    task automatic test_chain();
        logic [255:0] got, exp;
        int lat, pulses, terr, berr;
        load_block(ABCD_BLOCK1);
        model_run(1'b1, exp);
        run_block(1'b1, 0, 0, got, lat, pulses, terr, berr);
        checks++; if (got !== exp) begin errors++; $display("FAIL chain_blk1 got %h exp %h", got, exp); end
        load_block(ABCD_BLOCK2);
        model_run(1'b0, exp);
`ifdef SM3_CHAIN_EN
        exp = ABCD_DIGEST;
`endif
        run_block(1'b0, 0, 0, got, lat, pulses, terr, berr);
        checks++; if (got !== exp) begin errors++; $display("FAIL chain_blk2 got %h exp %h", got, exp); end
        checks++; if (lat != 67) begin errors++; $display("FAIL chain_latency got %0d exp 67", lat); end
    endtask

    task automatic test_reset_abort();
        logic [255:0] got, exp;
        int lat, pulses, terr, berr;
        load_block(ABC_BLOCK);
        run_block(1'b1, 0, 22, got, lat, pulses, terr, berr);
        mv = IV;
        checks++; if (pulses != 0) begin errors++; $display("FAIL abort_pulses got %0d exp 0", pulses); end
        checks++; if (got !== 256'h0) begin errors++; $display("FAIL abort_hash got %h exp 0", got); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
        model_run(1'b1, exp);
        run_block(1'b1, 0, 0, got, lat, pulses, terr, berr);
        checks++; if (got !== ABC_DIGEST) begin errors++; $display("FAIL post_abort_digest got %h exp %h", got, ABC_DIGEST); end
        checks++; if (lat != 67) begin errors++; $display("FAIL post_abort_latency got %0d exp 67", lat); end
    endtask

    task automatic test_random();
        logic [255:0] got, exp;
        logic [511:0] blk;
        logic         first;
        int lat, pulses, terr, berr;
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 16; i++) blk[32*i +: 32] = $urandom;
            first = 1'($urandom_range(0, 1));
            load_block(blk);
            model_run(first, exp);
            run_block(first, 0, 0, got, lat, pulses, terr, berr);
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL random_digest[%0d] got %h exp %h", n, got, exp);
            end
            checks++;
            if (pulses != 1 || lat != 67) begin
                errors++; $display("FAIL random_timing[%0d] got %0d pulses lat %0d exp 1 lat 67", n, pulses, lat);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; first_block = 1'b0; extend_valid = 1'b0;
        mv  = IV;
        for (int i = 0; i < 132; i++) ram[i] = 32'h0;
        test_reset();
        test_abc();
        test_start_guard();
        test_chain();
        test_reset_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sm3_compress.md
SM3_COMPRESS -- requirements
Module: sm3_compress

Interface
REQ-001 SHALL have port i_clk  input  1  sole clock; all state changes on rising edge.
REQ-002 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port i_start  input  1  one-cycle request to compress the block currently held in the schedule RAM.
REQ-004 SHALL have port i_first_block  input  1  sampled with i_start; 1 = chain from IV, 0 = chain from previous digest.
REQ-005 SHALL have port i_extend_valid  input  1  schedule-ready flag from the message-expansion block.
REQ-006 SHALL have ports o_rd_addr0 / o_rd_addr1  output  8 each  registered read addresses into the 132x32 schedule RAM (W at 0..67, W' at 68..131).
REQ-007 SHALL have ports i_rd_data0 / i_rd_data1  input  32 each  RAM data, combinationally valid in the same cycle as the registered address.
REQ-008 SHALL have port o_busy  output  1  high from accepted start until o_hash_valid.
REQ-009 SHALL have port o_hash  output  256  digest V(i+1), word A in [255:224] ... H in [31:0].
REQ-010 SHALL have port o_hash_valid  output  1  one-cycle pulse when o_hash is updated.

Function
REQ-011 SHALL implement FSM IDLE -> LOAD -> ROUND -> FINAL -> IDLE; no other states reachable.
REQ-012 IDLE SHALL accept i_start only when i_extend_valid=1; otherwise i_start is ignored with no state change.
REQ-013 i_start while o_busy=1 SHALL be ignored and SHALL NOT restart or corrupt the round sequence.
REQ-014 LOAD (1 cycle) SHALL copy chaining value V into A..H, set round counter j=0, and set o_rd_addr0=0 and o_rd_addr1=68.
REQ-015 ROUND SHALL last exactly 64 cycles and perform one round per cycle using Wj=i_rd_data0 and W'j=i_rd_data1, advancing the addresses to j+1 and 68+j+1 at the same edge.
REQ-016 Round arithmetic SHALL be modulo 2^32, with <<< denoting 32-bit rotate: SS1=((A<<<12)+E+(Tj<<<(j mod 32)))<<<7; SS2=SS1^(A<<<12); TT1=FF+D+SS2+W'j; TT2=GG+H+SS1+Wj.
REQ-017 Tj SHALL be 79CC4519 for j<16 and 7A879D8A for j>=16.
REQ-018 FF/GG SHALL be X^Y^Z for j<16; for j>=16, FF=(A&B)|(A&C)|(B&C) and GG=(E&F)|(~E&G).
REQ-019 Each round SHALL update D<=C, C<=B<<<9, B<=A, A<=TT1, H<=G, G<=F<<<19, F<=E, E<=P0(TT2), where P0(X)=X^(X<<<9)^(X<<<17).
REQ-020 FINAL (1 cycle) SHALL write o_hash<=V^{A..H} and V<=the same value, and SHALL pulse o_hash_valid.
REQ-021 The o_hash_valid pulse SHALL occur exactly 67 cycles after the cycle in which start was accepted.
REQ-022 o_hash SHALL hold its value until the next FINAL or reset.
REQ-023 o_rd_addr0/1 SHALL hold their last value outside ROUND, and the block SHALL never drive an address above 131.

Reset
REQ-024 On i_rst: state=IDLE, j=0, o_busy=0, o_hash_valid=0, o_hash=0, o_rd_addr0=0, o_rd_addr1=0, A..H=0.
REQ-025 On i_rst: V SHALL be set to IV = 7380166F 4914B2B9 172442D7 DA8A0600 A96F30BC 163138AA E38DEE4D B0FB0E4E.
REQ-026 Reset asserted mid-operation SHALL abort the operation; no o_hash_valid pulse SHALL follow, and the next start SHALL behave as after power-up.

Configuration
REQ-027 Macro SM3_CHAIN_EN: when defined, LOAD SHALL use IV when i_first_block=1 and the stored V when i_first_block=0 (multi-block messages).
REQ-028 When SM3_CHAIN_EN is undefined, i_first_block SHALL be ignored and LOAD SHALL always use IV; the V register SHALL not be retained (single-block only); ports SHALL be unchanged.

Verification
REQ-029 Model RAM holds the expansion of the "abc" block (61626380, 0 x 14, 00000018); i_start with i_first_block=1 -> o_hash=66C7F0F4 62EEEDD9 D1F2D46B DC10E4E2 4167C487 5CF2F7A2 297DA02B 8F4BA8E0, pulse 67 cycles after start.
REQ-030 Address trace during ROUND -> o_rd_addr0 steps 0..63 and o_rd_addr1 steps 68..131, one step per cycle with no gaps.
REQ-031 i_start with i_extend_valid=0, then i_start pulsed at cycle 30 of a run -> first start ignored; the run completes once with the correct digest and no second pulse.
REQ-032 Two-block 64x"abcd" message with SM3_CHAIN_EN, second block started with i_first_block=0 -> digest DEBE9FF9 2275B8A1 38604889 C18E5A4D 6FDB70E5 387E5765 293DCBA3 9C0C5732; without the macro, the second block digest equals the IV-seeded result.
REQ-033 i_rst asserted at round 20 -> no o_hash_valid pulse, o_hash=0, and a following "abc" run yields the REQ-029 digest.
